// File: rtl/ram_block_mover.sv
// Word-copy DMA master for the data RAM port: copies Length words from SrcAddr to DstAddr, one word per two cycles.
// Optional running checksum of copied words is enabled by defining RAM_MOVER_CHECKSUM_EN.
module ram_block_mover #(
   parameter int unsigned ADDR_WIDTH = 14,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic [ADDR_WIDTH-1:0] SrcAddr,
   input  logic [ADDR_WIDTH-1:0] DstAddr,
   input  logic [ADDR_WIDTH:0]   Length,
   output logic                  Busy,
   output logic                  Done,
   output logic [ADDR_WIDTH-1:0] MemAddress,
   output logic                  MemWrite,
   output logic [DATA_WIDTH-1:0] MemWriteData,
`ifdef RAM_MOVER_CHECKSUM_EN
   output logic [DATA_WIDTH-1:0] Checksum,
`endif
   input  logic [DATA_WIDTH-1:0] MemReadData
);

   localparam int unsigned LEN_W = ADDR_WIDTH + 1;
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_src;
   logic [ADDR_WIDTH-1:0] r_dst;
   logic [LEN_W-1:0]      r_rem;
   logic [DATA_WIDTH-1:0] r_buf;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_we;

   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] w_src_nxt;
   logic [ADDR_WIDTH-1:0] w_dst_nxt;
   logic [LEN_W-1:0]      w_rem_nxt;
   logic [DATA_WIDTH-1:0] w_buf_nxt;
   logic [ADDR_WIDTH-1:0] w_addr_nxt;
   logic                  w_busy_nxt;
   logic                  w_done_nxt;
   logic                  w_we_nxt;
   logic [LEN_W-1:0]      w_len_clamped;

`ifdef RAM_MOVER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] r_cks;
   logic [DATA_WIDTH-1:0] w_cks_nxt;
`endif

   assign w_len_clamped = (Length > MAX_LEN) ? MAX_LEN : Length;

   // Next-state and next-output decode; outputs are registered so they track the registered state.
   always_comb begin
      w_state_nxt = r_state;
      w_src_nxt   = r_src;
      w_dst_nxt   = r_dst;
      w_rem_nxt   = r_rem;
      w_buf_nxt   = r_buf;
      w_addr_nxt  = r_addr;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_we_nxt    = 1'b0;
`ifdef RAM_MOVER_CHECKSUM_EN
      w_cks_nxt   = r_cks;
`endif
      case (r_state)
         S_IDLE: begin
            if (Start) begin
               w_src_nxt = SrcAddr;
               w_dst_nxt = DstAddr;
               w_rem_nxt = w_len_clamped;
`ifdef RAM_MOVER_CHECKSUM_EN
               w_cks_nxt = '0;
`endif
               if (w_len_clamped == '0) begin
                  w_state_nxt = S_DONE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = S_READ;
                  w_busy_nxt  = 1'b1;
                  w_addr_nxt  = SrcAddr;
               end
            end
         end
         S_READ: begin
            // RAM read is sampled here, while MemWrite is low, so write-through never leaks in.
            w_buf_nxt   = MemReadData;
            w_state_nxt = S_WRITE;
            w_busy_nxt  = 1'b1;
            w_we_nxt    = 1'b1;
            w_addr_nxt  = r_dst;
         end
         S_WRITE: begin
            w_src_nxt = r_src + ADDR_WIDTH'(1);
            w_dst_nxt = r_dst + ADDR_WIDTH'(1);
            w_rem_nxt = r_rem - LEN_W'(1);
`ifdef RAM_MOVER_CHECKSUM_EN
            w_cks_nxt = r_cks + r_buf;
`endif
            if (r_rem == LEN_W'(1)) begin
               w_state_nxt = S_DONE;
               w_done_nxt  = 1'b1;
            end else begin
               w_state_nxt = S_READ;
               w_busy_nxt  = 1'b1;
               w_addr_nxt  = r_src + ADDR_WIDTH'(1);
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state <= S_IDLE;
         r_src   <= '0;
         r_dst   <= '0;
         r_rem   <= '0;
         r_buf   <= '0;
         r_addr  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_we    <= 1'b0;
`ifdef RAM_MOVER_CHECKSUM_EN
         r_cks   <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_src   <= w_src_nxt;
         r_dst   <= w_dst_nxt;
         r_rem   <= w_rem_nxt;
         r_buf   <= w_buf_nxt;
         r_addr  <= w_addr_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_we    <= w_we_nxt;
`ifdef RAM_MOVER_CHECKSUM_EN
         r_cks   <= w_cks_nxt;
`endif
      end
   end

   assign Busy         = r_busy;
   assign Done         = r_done;
   assign MemAddress   = r_addr;
   assign MemWrite     = r_we;
   assign MemWriteData = r_buf;
`ifdef RAM_MOVER_CHECKSUM_EN
   assign Checksum     = r_cks;
`endif

endmodule

// File: tb/tb_ram_block_mover.sv
// Bench for ram_block_mover: behavioural RAM, write scoreboard with a monitor, directed copy jobs.
module tb_ram_block_mover;

   localparam int unsigned AW = 14;
   localparam int unsigned DW = 32;

   logic          Clock;
   logic          Reset;
   logic          Start;
   logic [AW-1:0] SrcAddr;
   logic [AW-1:0] DstAddr;
   logic [AW:0]   Length;
   logic          Busy;
   logic          Done;
   logic [AW-1:0] MemAddress;
   logic          MemWrite;
   logic [DW-1:0] MemWriteData;
   logic [DW-1:0] MemReadData;
`ifdef RAM_MOVER_CHECKSUM_EN
   logic [DW-1:0] Checksum;
`endif

   logic [DW-1:0] ram [0:(1<<AW)-1];

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;
   wr_t exp_q[$];

   int tests;
   int fails;

   ram_block_mover #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .Start        (Start),
      .SrcAddr      (SrcAddr),
      .DstAddr      (DstAddr),
      .Length       (Length),
      .Busy         (Busy),
      .Done         (Done),
      .MemAddress   (MemAddress),
      .MemWrite     (MemWrite),
      .MemWriteData (MemWriteData),
`ifdef RAM_MOVER_CHECKSUM_EN
      .Checksum     (Checksum),
`endif
      .MemReadData  (MemReadData)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   assign MemReadData = ram[MemAddress];

   always @(posedge Clock) begin
      if (MemWrite) ram[MemAddress] <= MemWriteData;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every RAM write the DUT issues must match the head of the expected-write queue.
   always @(negedge Clock) begin
      if (MemWrite) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with empty queue", MemAddress, MemWriteData);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("write_addr", 64'(MemAddress), 64'(e.a));
            check("write_data", 64'(MemWriteData), 64'(e.d));
         end
      end
   end

   task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endtask

   // Issues Start just after an edge, then observes cycles 1..budget after the accepting edge.
   task automatic run_job(input logic [AW-1:0] src, input logic [AW-1:0] dst, input logic [AW:0] len,
                          input int n_words, input int budget, input int restart_cyc, input int reset_cyc,
                          output int done_cyc, output int done_cnt, output int busy_bad);
      int busy_last;
      Start   = 1'b1;
      SrcAddr = src;
      DstAddr = dst;
      Length  = len;
      @(posedge Clock);
      #1;
      Start    = 1'b0;
      done_cyc = -1;
      done_cnt = 0;
      busy_bad = 0;
      busy_last = 2 * n_words;
      if (reset_cyc > 0 && reset_cyc < busy_last) busy_last = reset_cyc;
      for (int c = 1; c <= budget; c++) begin
         if (c > 1) begin
            @(posedge Clock);
            #1;
         end
         if (c == restart_cyc) begin
            Start   = 1'b1;
            SrcAddr = 14'h0050;
            DstAddr = 14'h0090;
            Length  = 15'd2;
         end else if (c == restart_cyc + 1) begin
            Start = 1'b0;
         end
         if (c == reset_cyc) Reset = 1'b1;
         else if (c == reset_cyc + 1) Reset = 1'b0;
         @(negedge Clock);
         if (Done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (Busy !== (c <= busy_last)) busy_bad++;
      end
   endtask

   int dc;
   int dn;
   int bb;

   initial begin
      tests   = 0;
      fails   = 0;
      Reset   = 1'b1;
      Start   = 1'b0;
      SrcAddr = '0;
      DstAddr = '0;
      Length  = '0;
      for (int i = 0; i < (1 << AW); i++) ram[i] = 32'hDEAD_0000 | 32'(i);

      repeat (3) @(posedge Clock);
      #1;
      Reset = 1'b0;
      @(negedge Clock);
      check("rst_busy", 64'(Busy), 64'd0);
      check("rst_done", 64'(Done), 64'd0);
      check("rst_memwrite", 64'(MemWrite), 64'd0);
      check("rst_memaddr", 64'(MemAddress), 64'd0);
      check("rst_wdata", 64'(MemWriteData), 64'd0);
      @(posedge Clock);
      #1;

      // Basic four-word copy
      ram[14'h10] = 32'd1; ram[14'h11] = 32'd2; ram[14'h12] = 32'd3; ram[14'h13] = 32'd4;
      push_wr(14'h80, 32'd1); push_wr(14'h81, 32'd2); push_wr(14'h82, 32'd3); push_wr(14'h83, 32'd4);
      run_job(14'h10, 14'h80, 15'd4, 4, 12, 0, 0, dc, dn, bb);
      check("t1_done_cycle", 64'(dc), 64'd9);
      check("t1_done_count", 64'(dn), 64'd1);
      check("t1_busy_window", 64'(bb), 64'd0);
      check("t1_queue_empty", 64'(exp_q.size()), 64'd0);
      check("t1_ram80", 64'(ram[14'h80]), 64'd1);
      check("t1_ram83", 64'(ram[14'h83]), 64'd4);
      check("t1_idle_memwrite", 64'(MemWrite), 64'd0);
      check("t1_idle_addr_hold", 64'(MemAddress), 64'h83);

      // Zero length: immediate Done, no RAM access
      run_job(14'h5, 14'h6, 15'd0, 0, 4, 0, 0, dc, dn, bb);
      check("t2_done_cycle", 64'(dc), 64'd1);
      check("t2_done_count", 64'(dn), 64'd1);
      check("t2_busy_window", 64'(bb), 64'd0);
      check("t2_ram6", 64'(ram[14'h6]), 64'hDEAD0006);

      // Source pointer wraps past the top of RAM
      ram[14'h3FFE] = 32'hA; ram[14'h3FFF] = 32'hB; ram[14'h0] = 32'hC; ram[14'h1] = 32'hD;
      push_wr(14'h100, 32'hA); push_wr(14'h101, 32'hB); push_wr(14'h102, 32'hC); push_wr(14'h103, 32'hD);
      run_job(14'h3FFE, 14'h0100, 15'd4, 4, 12, 0, 0, dc, dn, bb);
      check("t3_done_cycle", 64'(dc), 64'd9);
      check("t3_queue_empty", 64'(exp_q.size()), 64'd0);
      check("t3_ram103", 64'(ram[14'h103]), 64'hD);

      // Start while busy is ignored
      ram[14'h20] = 32'h11; ram[14'h21] = 32'h22; ram[14'h22] = 32'h33; ram[14'h23] = 32'h44;
      push_wr(14'h40, 32'h11); push_wr(14'h41, 32'h22); push_wr(14'h42, 32'h33); push_wr(14'h43, 32'h44);
      run_job(14'h20, 14'h40, 15'd4, 4, 16, 3, 0, dc, dn, bb);
      check("t4_done_cycle", 64'(dc), 64'd9);
      check("t4_done_count", 64'(dn), 64'd1);
      check("t4_busy_window", 64'(bb), 64'd0);
      check("t4_queue_empty", 64'(exp_q.size()), 64'd0);
      check("t4_ram90_untouched", 64'(ram[14'h90]), 64'hDEAD0090);

      // Reset in cycle 4 of an eight-word job
      for (int i = 0; i < 8; i++) ram[14'h200 + 14'(i)] = 32'h100 + 32'(i);
      push_wr(14'h300, 32'h100); push_wr(14'h301, 32'h101);
      run_job(14'h200, 14'h300, 15'd8, 8, 20, 0, 4, dc, dn, bb);
      check("t5_no_done", 64'(dn), 64'd0);
      check("t5_busy_window", 64'(bb), 64'd0);
      check("t5_queue_empty", 64'(exp_q.size()), 64'd0);
      check("t5_ram300", 64'(ram[14'h300]), 64'h100);
      check("t5_ram301", 64'(ram[14'h301]), 64'h101);
      check("t5_ram302", 64'(ram[14'h302]), 64'hDEAD0302);
      check("t5_ram307", 64'(ram[14'h307]), 64'hDEAD0307);
      check("t5_memwrite", 64'(MemWrite), 64'd0);

      // Overlapping forward copy re-copies the first word
      ram[14'h400] = 32'd7; ram[14'h401] = 32'd8; ram[14'h402] = 32'd9;
      push_wr(14'h401, 32'd7); push_wr(14'h402, 32'd7); push_wr(14'h403, 32'd7);
      run_job(14'h400, 14'h401, 15'd3, 3, 10, 0, 0, dc, dn, bb);
      check("t6_done_cycle", 64'(dc), 64'd7);
      check("t6_queue_empty", 64'(exp_q.size()), 64'd0);
      check("t6_ram403", 64'(ram[14'h403]), 64'd7);

`ifdef RAM_MOVER_CHECKSUM_EN
      ram[14'h600] = 32'hFFFF_FFFF; ram[14'h601] = 32'h0000_0002;
      push_wr(14'h700, 32'hFFFF_FFFF); push_wr(14'h701, 32'h0000_0002);
      run_job(14'h600, 14'h700, 15'd2, 2, 8, 0, 0, dc, dn, bb);
      check("t7_done_cycle", 64'(dc), 64'd5);
      check("t7_checksum", 64'(Checksum), 64'h1);
`endif

      // Oversized length clamps to a full-RAM copy (in place, so contents are unchanged)
      for (int i = 0; i < (1 << AW); i++) begin
         ram[i] = 32'(i) * 32'd3 + 32'd1;
         push_wr(14'(i), 32'(i) * 32'd3 + 32'd1);
      end
      run_job(14'h0, 14'h0, 15'h7FFF, 1 << AW, (2 << AW) + 3, 0, 0, dc, dn, bb);
      check("t8_done_cycle", 64'(dc), 64'((2 << AW) + 1));
      check("t8_done_count", 64'(dn), 64'd1);
      check("t8_busy_window", 64'(bb), 64'd0);
      check("t8_queue_empty", 64'(exp_q.size()), 64'd0);
      check("t8_ram3fff", 64'(ram[14'h3FFF]), 64'(32'h3FFF * 32'd3 + 32'd1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
